// File: rtl/fb_wr_ctrl.sv
// fb_wr_ctrl: pixel stream to BRAM frame writer with FIFO, SOF resync, overflow and optional ping-pong (FB_DOUBLE_BUF_EN)
module fb_wr_ctrl #(
  parameter int PIX_W      = 8,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pixel_i,
  input  logic              pixel_en_i,
  input  logic              sof_i,
  output logic              pixel_rdy_o,
  input  logic              hold_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [PIX_W-1:0]  d2mema_o,
  output logic              frame_done_o,
  output logic              rd_buf_sel_o,
  output logic              resync_o,
  output logic              ovf_o
);
  localparam int FRAME_PIX = H_RES * V_RES;
  localparam int FA_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] FP_A = ADDR_W'(FRAME_PIX);
  typedef enum logic [1:0] {IDLE, WR, SWAP} state_t;
  state_t state_q, state_d;
  logic [PIX_W:0] fifo_q [FIFO_DEPTH];
  logic [FA_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FA_W:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d, addr_q, addr_d, base;
  logic [PIX_W-1:0] data_q, data_d, head_pix;
  logic we_q, we_d, resync_q, resync_d, ovf_q, ovf_d, wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
  logic empty, full, push, pop, head_sof, resync, last;
  always_comb begin
    empty = cnt_q == '0;
    full = cnt_q == (FA_W+1)'(FIFO_DEPTH);
    push = pixel_en_i & !full;
    // IDLE pops too, so a pixel reaches BRAM two cycles after acceptance
    pop = (state_q != SWAP) & !empty & !hold_i;
    {head_sof, head_pix} = fifo_q[rd_ptr_q];
    wr_ptr_d = wr_ptr_q + FA_W'(push);
    rd_ptr_d = rd_ptr_q + FA_W'(pop);
    cnt_d = cnt_q + (FA_W+1)'(push) - (FA_W+1)'(pop);
    resync = pop & head_sof & (pix_cnt_q != '0);
    last = pop & !resync & (pix_cnt_q == LAST);
`ifdef FB_DOUBLE_BUF_EN
    base = wr_buf_q ? FP_A : '0;
    wr_buf_d = (state_q == SWAP) ? !wr_buf_q : wr_buf_q;
    rd_buf_d = (state_q == SWAP) ? wr_buf_q : rd_buf_q;
`else
    base = '0;
    wr_buf_d = 1'b0;
    rd_buf_d = 1'b0;
`endif
    addr_d = pop ? base + (resync ? '0 : pix_cnt_q) : addr_q;
    data_d = pop ? head_pix : data_q;
    we_d = pop;
    resync_d = resync;
    ovf_d = ovf_q | (pixel_en_i & full);
    // the counter parks at the last index until SWAP clears it
    pix_cnt_d = (state_q == SWAP) ? '0 : resync ? ADDR_W'(1) : (pop & !last) ? pix_cnt_q + ADDR_W'(1) : pix_cnt_q;
    state_d = (state_q == SWAP) ? ((!empty && !hold_i) ? WR : IDLE) : last ? SWAP : pop ? WR : IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {sof_i, pixel_i};
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      pix_cnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      resync_q <= 1'b0;
      ovf_q <= 1'b0;
      wr_buf_q <= 1'b0;
      rd_buf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      pix_cnt_q <= pix_cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      resync_q <= resync_d;
      ovf_q <= ovf_d;
      wr_buf_q <= wr_buf_d;
      rd_buf_q <= rd_buf_d;
    end
  end
  assign pixel_rdy_o = !full;
  assign ena_o = we_q;
  assign wea_o = we_q;
  assign addra_o = addr_q;
  assign d2mema_o = data_q;
  assign frame_done_o = state_q == SWAP;
  assign rd_buf_sel_o = rd_buf_q;
  assign resync_o = resync_q;
  assign ovf_o = ovf_q;
endmodule

// File: tb/tb_fb_wr_ctrl.sv
// tb_fb_wr_ctrl: directed self-checking bench for fb_wr_ctrl (4x2 frame, 4-deep FIFO)
module tb_fb_wr_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] pixel_i = 0;
  logic pixel_en_i = 0, sof_i = 0, hold_i = 0;
  logic pixel_rdy_o, ena_o, wea_o, frame_done_o, rd_buf_sel_o, resync_o, ovf_o;
  logic [4:0] addra_o;
  logic [7:0] d2mema_o;
  int checks = 0, errors = 0;
  int wr_cnt, done_cnt, res_cnt, drops, done_wc, res_wc;
  logic [4:0] wa [64];
  logic [7:0] wd [64];
  fb_wr_ctrl #(.PIX_W(8), .H_RES(4), .V_RES(2), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pixel_i(pixel_i), .pixel_en_i(pixel_en_i), .sof_i(sof_i),
    .pixel_rdy_o(pixel_rdy_o), .hold_i(hold_i), .ena_o(ena_o), .wea_o(wea_o),
    .addra_o(addra_o), .d2mema_o(d2mema_o), .frame_done_o(frame_done_o),
    .rd_buf_sel_o(rd_buf_sel_o), .resync_o(resync_o), .ovf_o(ovf_o));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ena_o && wea_o && wr_cnt < 64) begin
      wa[wr_cnt] = addra_o;
      wd[wr_cnt] = d2mema_o;
      wr_cnt++;
    end
    if (frame_done_o) begin
      if (done_cnt == 0) done_wc = wr_cnt;
      done_cnt++;
    end
    if (resync_o) begin
      res_cnt++;
      res_wc = wr_cnt;
    end
    if (pixel_en_i && !pixel_rdy_o) drops++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    wr_cnt = 0; done_cnt = 0; res_cnt = 0; drops = 0; done_wc = -1; res_wc = -1;
  endtask
  task automatic drive(input logic [7:0] p, input logic s);
    @(posedge clk); #1;
    pixel_i = p; sof_i = s; pixel_en_i = 1;
  endtask
  task automatic idle(input int n);
    @(posedge clk); #1;
    pixel_en_i = 0; sof_i = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_rst();
    @(posedge clk); #1;
    rst = 1; pixel_en_i = 0; sof_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ena", ena_o, 0);
    chk("rst_wea", wea_o, 0);
    chk("rst_addr", addra_o, 0);
    chk("rst_data", d2mema_o, 0);
    chk("rst_done", frame_done_o, 0);
    chk("rst_rdsel", rd_buf_sel_o, 0);
    chk("rst_resync", resync_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_rdy", pixel_rdy_o, 1);
    rst = 0;
    clr();
    for (int i = 0; i < 16; i++) drive(8'h10 + 8'(i), i == 0);
    idle(10);
    chk("bb_writes", wr_cnt, 16);
    chk("bb_drops", drops, 0);
    chk("bb_ovf", ovf_o, 0);
    chk("bb_done_cnt", done_cnt, 2);
    chk("bb_done_at", done_wc, 8);
    for (int i = 0; i < 8; i++) begin
      chk("bb_f1_addr", wa[i], i);
      chk("bb_f1_data", wd[i], 8'h10 + i);
    end
`ifdef FB_DOUBLE_BUF_EN
    for (int i = 8; i < 16; i++) chk("bb_f2_addr", wa[i], i);
    chk("bb_rdsel", rd_buf_sel_o, 1);
`else
    for (int i = 8; i < 16; i++) chk("bb_f2_addr", wa[i], i - 8);
    chk("bb_rdsel", rd_buf_sel_o, 0);
`endif
    for (int i = 8; i < 16; i++) chk("bb_f2_data", wd[i], 8'h10 + i);
    clr();
    hold_i = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 4) chk("hold_rdy", pixel_rdy_o, 0);
      pixel_i = 8'h20 + 8'(i); sof_i = 0; pixel_en_i = 1;
    end
    idle(2);
    chk("hold_ovf", ovf_o, 1);
    chk("hold_drops", drops, 2);
    chk("hold_nowr", wr_cnt, 0);
    hold_i = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("hold_writes", wr_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk("hold_addr", wa[i], i);
      chk("hold_data", wd[i], 8'h20 + i);
    end
    do_rst();
    chk("rst2_ovf", ovf_o, 0);
    clr();
    drive(8'h30, 1);
    drive(8'h31, 0);
    chk("lat_n1_ena", ena_o, 0);
    drive(8'h32, 0);
    chk("lat_n2_ena", ena_o, 1);
    chk("lat_n2_addr", addra_o, 0);
    chk("lat_n2_data", d2mema_o, 8'h30);
    drive(8'hAA, 1);
    idle(6);
    chk("sof_writes", wr_cnt, 4);
    chk("sof_resync_cnt", res_cnt, 1);
    chk("sof_resync_at", res_wc, 4);
    chk("sof_done", done_cnt, 0);
    chk("sof_addr3", wa[3], 0);
    chk("sof_data3", wd[3], 8'hAA);
    chk("sof_addr2", wa[2], 2);
    chk("sof_data2", wd[2], 8'h32);
    do_rst();
    clr();
    for (int i = 0; i < 5; i++) drive(8'h40 + 8'(i), i == 0);
    @(posedge clk); #1;
    rst = 1; pixel_en_i = 0; sof_i = 0;
    @(posedge clk); #1;
    chk("mid_rst_ena", ena_o, 0);
    chk("mid_rst_done", frame_done_o, 0);
    chk("mid_rst_rdy", pixel_rdy_o, 1);
    chk("mid_rst_resync", resync_o, 0);
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_nodone", done_cnt, 0);
    clr();
    for (int i = 0; i < 8; i++) drive(8'h50 + 8'(i), i == 0);
    idle(6);
    chk("new_writes", wr_cnt, 8);
    chk("new_done", done_cnt, 1);
    chk("new_addr0", wa[0], 0);
    chk("new_data0", wd[0], 8'h50);
    chk("new_addr7", wa[7], 7);
    chk("new_data7", wd[7], 8'h57);
    chk("new_rdsel", rd_buf_sel_o, 0);
    chk("new_resync", res_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
